// File: rtl/systolic_2x2.sv
// rtl/systolic_2x2.sv - 2x2 output-stationary systolic array multiplying two 2x2 matrices of unsigned 8-bit elements
//
// Ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset
//   start in   1  request a new multiply, sampled only in IDLE
//   matA  in  32  operand A: [7:0]=A00 [15:8]=A01 [23:16]=A10 [31:24]=A11
//   matB  in  32  operand B, same packing as matA
//   ds    in   2  display-stage status, 2'b10 acknowledges the result in DONE
//   state out  2  phase: 00 IDLE, 01 LOAD, 10 RUN, 11 DONE
//   ret   out 32  result C = A x B, packed as matA
//   busy  out  1  high in LOAD or RUN
//
// Build option: define SYSTOLIC_SAT_EN to saturate each result element at
// 8'hFF; by default each element is its accumulator modulo 256.
module systolic_2x2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] matA,
    input  logic [31:0] matB,
    input  logic [1:0]  ds,
    output logic [1:0]  state,
    output logic [31:0] ret,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      state_q;
    logic [1:0]  t_q;
    logic        busy_q;
    logic [31:0] ret_q;
    logic [31:0] ret_d;
    logic [31:0] a_mat_q;
    logic [31:0] b_mat_q;

    // a leaving column 0 eastward (one per row), b leaving row 0 southward (one per column)
    logic [7:0]  a_skew_q [2];
    logic [7:0]  b_skew_q [2];

    // PE index p = 2*i + j
    logic [16:0] acc_q [4];
    logic [16:0] acc_d [4];
    logic [7:0]  pe_a  [4];
    logic [7:0]  pe_b  [4];
    logic [7:0]  a_edge [2];
    logic [7:0]  b_edge [2];

    function automatic logic [7:0] elem(input logic [31:0] m, input int r, input int c);
        return m[(r*2+c)*8 +: 8];
    endfunction

    function automatic logic [7:0] to_elem(input logic [16:0] acc);
`ifdef SYSTOLIC_SAT_EN
        return (acc > 17'd255) ? 8'hFF : acc[7:0];
`else
        return acc[7:0];
`endif
    endfunction

    always_comb begin
        // Edge feeds are skewed so that row i / column j start i / j cycles late.
        a_edge[0] = (t_q == 2'd0) ? elem(a_mat_q, 0, 0) :
                    (t_q == 2'd1) ? elem(a_mat_q, 0, 1) : 8'd0;
        a_edge[1] = (t_q == 2'd1) ? elem(a_mat_q, 1, 0) :
                    (t_q == 2'd2) ? elem(a_mat_q, 1, 1) : 8'd0;
        b_edge[0] = (t_q == 2'd0) ? elem(b_mat_q, 0, 0) :
                    (t_q == 2'd1) ? elem(b_mat_q, 1, 0) : 8'd0;
        b_edge[1] = (t_q == 2'd1) ? elem(b_mat_q, 0, 1) :
                    (t_q == 2'd2) ? elem(b_mat_q, 1, 1) : 8'd0;

        pe_a[0] = a_edge[0];
        pe_b[0] = b_edge[0];
        pe_a[1] = a_skew_q[0];
        pe_b[1] = b_edge[1];
        pe_a[2] = a_edge[1];
        pe_b[2] = b_skew_q[0];
        pe_a[3] = a_skew_q[1];
        pe_b[3] = b_skew_q[1];

        for (int p = 0; p < 4; p++) begin
            acc_d[p] = acc_q[p] + {1'b0, 16'(pe_a[p]) * 16'(pe_b[p])};
        end

        // Built from acc_d so the final RUN step lands in ret on the same edge as DONE.
        ret_d = {to_elem(acc_d[3]), to_elem(acc_d[2]), to_elem(acc_d[1]), to_elem(acc_d[0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= 2'd0;
            busy_q  <= 1'b0;
            ret_q   <= 32'd0;
            a_mat_q <= 32'd0;
            b_mat_q <= 32'd0;
            for (int k = 0; k < 2; k++) begin
                a_skew_q[k] <= 8'd0;
                b_skew_q[k] <= 8'd0;
            end
            for (int p = 0; p < 4; p++) begin
                acc_q[p] <= 17'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    a_mat_q <= matA;
                    b_mat_q <= matB;
                    t_q     <= 2'd0;
                    for (int k = 0; k < 2; k++) begin
                        a_skew_q[k] <= 8'd0;
                        b_skew_q[k] <= 8'd0;
                    end
                    for (int p = 0; p < 4; p++) begin
                        acc_q[p] <= 17'd0;
                    end
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    for (int p = 0; p < 4; p++) begin
                        acc_q[p] <= acc_d[p];
                    end
                    a_skew_q[0] <= pe_a[0];
                    a_skew_q[1] <= pe_a[2];
                    b_skew_q[0] <= pe_b[0];
                    b_skew_q[1] <= pe_b[1];
                    t_q         <= t_q + 2'd1;
                    if (t_q == 2'd3) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        ret_q   <= ret_d;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here, even alongside an ack
                    if (ds == 2'b10) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state = state_q;
    assign ret   = ret_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_systolic_2x2.sv
// tb/tb_systolic_2x2.sv - directed self-checking bench for systolic_2x2
module tb_systolic_2x2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] matA;
    logic [31:0] matB;
    logic [1:0]  ds;
    logic [1:0]  state;
    logic [31:0] ret;
    logic        busy;

    int total = 0;
    int bad   = 0;

`ifdef SYSTOLIC_SAT_EN
    localparam logic [31:0] FF_EXP = 32'hFFFFFFFF;
`else
    localparam logic [31:0] FF_EXP = 32'h02020202;
`endif

    systolic_2x2 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .matA  (matA),
        .matB  (matB),
        .ds    (ds),
        .state (state),
        .ret   (ret),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch a multiply from IDLE and wait (bounded) for DONE.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
        int n;
        matA  = a;
        matB  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (state !== 2'b11 && n < 20) begin
            step();
            n++;
        end
        check("reach_done", {30'd0, state}, 32'd3);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        matA  = 32'd0;
        matB  = 32'd0;
        ds    = 2'b00;
        step();
        step();
        rst = 1'b0;
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_ret", ret, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Basic product with exact latency
        matA  = 32'h04030201;
        matB  = 32'h08070605;
        start = 1'b1;
        step();
        start = 1'b0;
        check("lat_load_state", {30'd0, state}, 32'd1);
        check("lat_load_busy", {31'd0, busy}, 32'd1);
        step();
        check("lat_run_state", {30'd0, state}, 32'd2);
        step();
        step();
        step();
        check("lat_n4_state", {30'd0, state}, 32'd2);
        check("lat_n4_busy", {31'd0, busy}, 32'd1);
        step();
        check("lat_n5_state", {30'd0, state}, 32'd3);
        check("lat_n5_busy", {31'd0, busy}, 32'd0);
        check("basic_ret", ret, 32'h322B1613);
        ds = 2'b10;
        step();
        ds = 2'b00;
        check("ack_idle", {30'd0, state}, 32'd0);
        check("ack_ret_kept", ret, 32'h322B1613);
        step();
        check("idle_ret_kept", ret, 32'h322B1613);

        // Identity
        do_mult(32'h01000001, 32'h04030201);
        check("identity_ret", ret, 32'h04030201);
        ds = 2'b10;
        step();
        ds = 2'b00;

        // All-ones: wrap or saturate depending on build
        do_mult(32'hFFFFFFFF, 32'hFFFFFFFF);
        check("ones_ret", ret, FF_EXP);
        ds = 2'b10;
        step();
        ds = 2'b00;

        // start pulse, matA change and stray ack during RUN are all ignored
        matA  = 32'h04030201;
        matB  = 32'h08070605;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("nr_in_run", {30'd0, state}, 32'd2);
        start = 1'b1;
        matA  = 32'hAABBCCDD;
        ds    = 2'b10;
        step();
        start = 1'b0;
        check("nr_still_run", {30'd0, state}, 32'd2);
        step();
        ds = 2'b01;
        step();
        check("nr_n4_run", {30'd0, state}, 32'd2);
        step();
        check("nr_done", {30'd0, state}, 32'd3);
        check("nr_ret", ret, 32'h322B1613);

        // Hold in DONE without an ack
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_state", {30'd0, state}, 32'd3);
            check("hold_ret", ret, 32'h322B1613);
        end

        // Ack and start together: back to IDLE only
        ds    = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        ds    = 2'b00;
        check("ackstart_idle", {30'd0, state}, 32'd0);
        check("ackstart_ret", ret, 32'h322B1613);
        step();
        check("ackstart_stay_idle", {30'd0, state}, 32'd0);

        // Reset during RUN t=2 discards the partial result
        matA  = 32'h01000001;
        matB  = 32'h04030201;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("mid_run_state", {30'd0, state}, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_state", {30'd0, state}, 32'd0);
        check("midrst_ret", ret, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        do_mult(32'h04030201, 32'h08070605);
        check("after_rst_ret", ret, 32'h322B1613);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
